bf_input_queue: RTL and testbench
=================================

// Module: bf_input_queue
// PURPOSE
//   Input stage feeding the brainfuck core's ',' (read-byte) instruction.
//   Buffers bytes from uart_rx (one-cycle valid pulse per byte) in a FIFO and serves them to the core
//   over a req/ack handshake; the core stalls on ',' until a byte is acked.
//   Sits between uart_rx and core in bf_uart, mirroring the core->uart_tx output path.
// PARAMETERS
//   DATA_WIDTH  `DATA_WIDTH (8)  byte width, shared with core/ram/uart.
//   DEPTH       16               FIFO entries; power of two, >= 2.
//   PTR_W       $clog2(DEPTH)    pointer width (localparam, derived).
// PORTS
//   clk        in   1           system clock (post-IBUFGDS clk).
//   rst        in   1           synchronous reset, active-high.
//   rx_valid   in   1           one-cycle pulse: rx_data holds a new received byte.
//   rx_data    in   DATA_WIDTH  byte from uart_rx.
//   in_req     in   1           level; core is executing ',' and wants a byte.
//   in_ack     out  1           one-cycle pulse: in_data valid, request served.
//   in_data    out  DATA_WIDTH  byte delivered to core; holds value until next ack.
//   count      out  PTR_W+1     bytes currently stored (0..DEPTH).
//   overflow   out  1           sticky: a byte was dropped because FIFO was full.
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, in_ack=0, in_data=0, overflow=0; FIFO contents
//     not cleared; any pending request abandoned, any rx_valid that cycle ignored.
//   - Push: rx_valid=1 and (count<DEPTH or pop same cycle) -> write mem[wr_ptr], wr_ptr+1 mod DEPTH.
//   - Drop: rx_valid=1, count==DEPTH, no pop that cycle -> byte discarded, overflow<=1 until rst.
//   - Pop: in_req=1 and in_ack=0 and count!=0 -> next cycle in_ack=1, in_data=mem[rd_ptr]; rd_ptr+1.
//     Latency req->ack = 1 cycle when data present.
//   - in_req is ignored in the cycle in_ack=1 (core deasserts on ack); back-to-back ',' therefore
//     served no faster than every 2 cycles; never a double pop per request.
//   - Empty: in_req=1, count==0 -> no ack, wait; a byte pushed in cycle N is ackable at N+2
//     (write N, pop decision N+1, ack visible N+2). No bypass path.
//   - Simultaneous push+pop: count unchanged; at full the pop frees a slot and the push is accepted.
//   - count = push - pop each cycle, arithmetic in PTR_W+1 bits, never wraps past DEPTH or below 0.
//   - Pointers wrap modulo DEPTH; full/empty from count, not pointer compare.
//   - in_ack drops to 0 the cycle after assertion (pulse), in_data retained.
// CONFIGURATION
//   BF_INPUT_ECHO_EN defined: adds outputs echo_en (1) and echo_data (DATA_WIDTH); every accepted
//     (not dropped) byte is echoed as a one-cycle echo_en pulse the cycle after rx_valid, for OR-muxing
//     onto uart_tx; echo_en/echo_data reset to 0. Dropped bytes are not echoed.
//   Not defined: ports absent, no echo logic.
// STRUCTURE
//   - `DATA_WIDTH and a new `INQ_DEPTH default go in define.v; no other shared constants.
//   - One sub-module: sync_fifo (mem, wr/rd pointers, count, full/empty) reused later for an output
//     FIFO in front of uart_tx; bf_input_queue adds req/ack FSM (IDLE -> ACK -> IDLE), drop/overflow, echo.
// TESTING
//   1. Push 0x2C,0x41,0x42 (gapped rx_valid pulses), then in_req held -> three acks, in_data
//      0x2C,0x41,0x42 in order, count 3->0, each ack 1 cycle after req sampled.
//   2. in_req high with empty FIFO for 20 cycles -> no ack; rx_valid 0x7A at cycle N -> in_ack at N+2,
//      in_data=0x7A, count back to 0.
//   3. Push 17 bytes 0x00..0x10 with no pops (DEPTH=16) -> count=16, overflow=1, reading returns
//      0x00..0x0F only; overflow stays 1 after FIFO empties.
//   4. FIFO full, rx_valid 0x55 same cycle as pop -> no overflow, count stays 16, 0x55 read last.
//   5. rst asserted mid-stream with count=5 and in_req pending -> next cycle count=0, in_ack=0,
//      overflow=0, in_data=0; subsequent push/pop 0x33 works normally.
//   6. (BF_INPUT_ECHO_EN) push 0x68 -> echo_en pulse next cycle with echo_data=0x68; byte pushed at full
//      -> no echo_en.

Source files
------------

// File: rtl/bf_input_queue_pkg.sv
// Shared constants and types for the brainfuck input queue.
// BF_DATA_WIDTH is the byte width shared with core/ram/uart; INQ_DEPTH is the default FIFO depth.
package bf_input_queue_pkg;

    localparam int BF_DATA_WIDTH = 8;
    localparam int INQ_DEPTH     = 16;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } inq_state_t;

endpackage

// File: rtl/bf_input_queue_sync_fifo.sv
// Synchronous FIFO: memory, wrapping pointers, occupancy count, full/empty.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (show-ahead), count, full, empty.
// The caller must not push when full without a simultaneous pop, nor pop when empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [PTR_W:0]        count,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bf_input_queue.sv
// Input queue for the core's ',' instruction: buffers uart_rx bytes, serves them over req/ack.
// Ports: clk, rst (sync, active-high), rx_valid/rx_data, in_req/in_ack/in_data, count, overflow.
// Optional macro BF_INPUT_ECHO_EN adds echo_en/echo_data, a one-cycle echo of every accepted byte.
module bf_input_queue
    import bf_input_queue_pkg::*;
#(
    parameter int DATA_WIDTH = BF_DATA_WIDTH,
    parameter int DEPTH      = INQ_DEPTH,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  in_req,
    output logic                  in_ack,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic [PTR_W:0]        count,
`ifdef BF_INPUT_ECHO_EN
    output logic                  echo_en,
    output logic [DATA_WIDTH-1:0] echo_data,
`endif
    output logic                  overflow
);

    inq_state_t            state;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head;

    // A request is only taken in IDLE, so the ack cycle never pops again.
    assign pop  = !rst && (state == ST_IDLE) && in_req && !empty;
    // At full a same-cycle pop frees the slot for the incoming byte.
    assign push = !rst && rx_valid && (!full || pop);
    assign drop = !rst && rx_valid && full && !pop;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (rx_data),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            in_ack   <= 1'b0;
            in_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (pop) begin
                        in_ack  <= 1'b1;
                        in_data <= head;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    in_ack <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    in_ack <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BF_INPUT_ECHO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_en   <= 1'b0;
            echo_data <= '0;
        end else begin
            echo_en <= push;
            if (push) begin
                echo_data <= rx_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bf_input_queue.sv
// Self-checking bench for bf_input_queue with a byte scoreboard.
// Define BF_INPUT_ECHO_EN to also exercise the echo outputs.
module tb_bf_input_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int PW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          in_req;
    logic          in_ack;
    logic [DW-1:0] in_data;
    logic [PW:0]   count;
    logic          overflow;
`ifdef BF_INPUT_ECHO_EN
    logic          echo_en;
    logic [DW-1:0] echo_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    bf_input_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .in_req    (in_req),
        .in_ack    (in_ack),
        .in_data   (in_data),
        .count     (count),
`ifdef BF_INPUT_ECHO_EN
        .echo_en   (echo_en),
        .echo_data (echo_data),
`endif
        .overflow  (overflow)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every ack must deliver the oldest accepted byte.
    always @(negedge clk) begin
        if (in_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 1, 0);
            end else begin
                check("ack_data", int'(in_data), int'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one rx_valid pulse in the current cycle.
    task automatic send(input logic [DW-1:0] d, input bit acc);
        rx_valid = 1'b1;
        rx_data  = d;
        if (acc) sb.push_back(d);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int exp_lat, input int exp_cnt);
        int lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (in_ack) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_cnt"}, int'(count), exp_cnt);
    endtask

    initial begin
        int no_ack;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        in_req   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_ack", int'(in_ack), 0);
        check("rst_data", int'(in_data), 0);
        check("rst_ovf", int'(overflow), 0);
        tick();

        // In-order delivery of gapped bytes
        send(8'h2C, 1'b1); tick();
        send(8'h41, 1'b1); tick();
        send(8'h42, 1'b1); tick();
        check("t1_count", int'(count), 3);
        in_req = 1'b1;
        wait_ack("t1_a0", 2, 2);
        wait_ack("t1_a1", 2, 1);
        wait_ack("t1_a2", 2, 0);
        in_req = 1'b0;
        tick();

        // Request against empty FIFO
        in_req = 1'b1;
        no_ack = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_ack) no_ack++;
        end
        check("t2_no_ack", no_ack, 0);
        tick();
        send(8'h7A, 1'b1);
        wait_ack("t2_ack", 2, 0);
        in_req = 1'b0;
        tick();

        // Overflow: 17 bytes into 16 entries
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
        @(negedge clk);
        check("t3_full_cnt", int'(count), 16);
        check("t3_no_ovf", int'(overflow), 0);
        tick();
        send(8'h10, 1'b0);
        @(negedge clk);
        check("t3_cnt", int'(count), 16);
        check("t3_ovf", int'(overflow), 1);
        tick();
        in_req = 1'b1;
        for (int i = 0; i < 16; i++) wait_ack("t3_rd", 2, 15 - i);
        in_req = 1'b0;
        tick();
        tick();
        check("t3_ovf_sticky", int'(overflow), 1);
        check("t3_empty", int'(count), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_ovf", int'(overflow), 0);
        tick();

        // Push and pop in the same cycle at full
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        in_req   = 1'b1;
        sb.push_back(8'h55);
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check("t4_ack", int'(in_ack), 1);
        check("t4_cnt", int'(count), 16);
        check("t4_ovf", int'(overflow), 0);
        for (int i = 0; i < 16; i++) wait_ack("t4_rd", 2, 15 - i);
        in_req = 1'b0;
        tick();

        // Reset with data stored and a request pending
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i), 1'b1);
        check("t5_cnt5", int'(count), 5);
        in_req = 1'b1;
        rst    = 1'b1;
        sb.delete();
        tick();
        rst    = 1'b0;
        in_req = 1'b0;
        @(negedge clk);
        check("t5_cnt", int'(count), 0);
        check("t5_ack", int'(in_ack), 0);
        check("t5_ovf", int'(overflow), 0);
        check("t5_data", int'(in_data), 0);
        tick();
        in_req = 1'b1;
        send(8'h33, 1'b1);
        wait_ack("t5_ack33", 2, 0);
        in_req = 1'b0;
        tick();

`ifdef BF_INPUT_ECHO_EN
        rx_valid = 1'b1;
        rx_data  = 8'h68;
        sb.push_back(8'h68);
        @(negedge clk);
        check("t6_echo_early", int'(echo_en), 0);
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        check("t6_echo_en", int'(echo_en), 1);
        check("t6_echo_data", int'(echo_data), 8'h68);
        tick();
        for (int i = 0; i < 15; i++) send(8'(8'hC0 + i), 1'b1);
        send(8'hEE, 1'b0);
        @(negedge clk);
        check("t6_drop_echo", int'(echo_en), 0);
        check("t6_drop_ovf", int'(overflow), 1);
        tick();
        in_req = 1'b1;
        for (int i = 0; i < 16; i++) wait_ack("t6_rd", 2, 15 - i);
        in_req = 1'b0;
        tick();
`endif

        repeat (4) tick();
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
